// File: rtl/noc_telem_pkg.sv
// -----------------------------------------------------------------------------
// noc_telem_pkg
// Shared types for the NoC telemetry window sampler: the queued record layout,
// the sampler FSM state encoding and the router counter width.
// -----------------------------------------------------------------------------
package noc_telem_pkg;

  localparam int CNT_W     = 32;
  localparam int MILLI_W   = 16;
  // The record carries the widest supported sequence number; the top keeps
  // only its configured SEQ_W low bits.
  localparam int SEQ_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BASELINE = 2'd1,
    RUN      = 2'd2,
    CAPTURE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [SEQ_MAX_W-1:0] seq;
    logic [CNT_W-1:0]     d_in;
    logic [CNT_W-1:0]     d_out;
    logic [CNT_W-1:0]     d_arb;
    logic [CNT_W-1:0]     d_buf;
    logic [MILLI_W-1:0]   peak_milli;
    logic [MILLI_W-1:0]   avgq_milli;
  } telem_rec_t;

endpackage

// File: rtl/noc_telem_rec_fifo.sv
// -----------------------------------------------------------------------------
// noc_telem_rec_fifo
// Synchronous FIFO of telem_rec_t with a registered head record.
// The head register only changes when a new record becomes the head, so it
// holds the last delivered record while the FIFO is empty.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   i_push        write i_data (accepted if not full, or full with a pop)
//   i_data        record to write
//   i_pop         pop request (ignored while empty)
//   o_head        registered head record
//   o_full        DEPTH records held
//   o_empty       no records held
// -----------------------------------------------------------------------------
module noc_telem_rec_fifo
  import noc_telem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_push,
  input  telem_rec_t i_data,
  input  logic       i_pop,
  output telem_rec_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  telem_rec_t       r_mem [DEPTH];
  telem_rec_t       r_head;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_pop;
  logic             w_push;
  logic [AW-1:0]    w_rd_next;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_head;

  assign w_pop     = i_pop && !o_empty;
  // A pop frees the slot this cycle, so a push into a full FIFO still fits.
  assign w_push    = i_push && (!o_full || w_pop);
  assign w_rd_next = r_rd_ptr + AW'(1);

  // Record storage needs no reset: slots are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_next;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);

      // Head refresh: first record into an empty FIFO, or the successor on a
      // pop (from storage if one is held, else the record pushed alongside).
      if (o_empty) begin
        if (w_push) r_head <= i_data;
      end else if (w_pop) begin
        if (r_count > CW'(1)) r_head <= r_mem[w_rd_next];
        else if (w_push)      r_head <= i_data;
      end
    end
  end

endmodule

// File: rtl/noc_telem_window_sampler.sv
// -----------------------------------------------------------------------------
// noc_telem_window_sampler
// Samples the cumulative telemetry counters of noc_router_enhanced over fixed
// windows. At each window end the per-window deltas (modulo 2^32) and the
// instantaneous milli metrics are queued as one record in a small FIFO that a
// consumer drains with a valid/ready handshake.
//
// Optional feature macro: NOC_TELEM_ARB_IRQ_EN
//   Adds input arb_threshold; irq_arb pulses for one cycle (the cycle after
//   the window end) when the window's arbitration-stall delta exceeds it.
//   Without the macro irq_arb is tied 0.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   enable                       sampling enable (level)
//   flits_in/out_count,
//   stall_arb/buf_count          router cumulative counters (32 bit)
//   peak_inflight_milli,
//   avg_queue_depth_milli        router instantaneous metrics (16 bit)
//   rec_valid / rec_ready        record handshake
//   rec_seq, rec_d_*, rec_*_milli  head record fields
//   dropped_count                records lost to a full FIFO (saturating)
//   overflow_sticky              set on the first drop until reset
//   irq_arb                      arbitration-stall threshold pulse
// -----------------------------------------------------------------------------
module noc_telem_window_sampler
  import noc_telem_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1024,
  parameter int FIFO_DEPTH    = 4,
  parameter int SEQ_W         = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [CNT_W-1:0]   flits_in_count,
  input  logic [CNT_W-1:0]   flits_out_count,
  input  logic [CNT_W-1:0]   stall_arb_count,
  input  logic [CNT_W-1:0]   stall_buf_count,
  input  logic [MILLI_W-1:0] peak_inflight_milli,
  input  logic [MILLI_W-1:0] avg_queue_depth_milli,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [SEQ_W-1:0]   rec_seq,
  output logic [CNT_W-1:0]   rec_d_in,
  output logic [CNT_W-1:0]   rec_d_out,
  output logic [CNT_W-1:0]   rec_d_arb,
  output logic [CNT_W-1:0]   rec_d_buf,
  output logic [MILLI_W-1:0] rec_peak_milli,
  output logic [MILLI_W-1:0] rec_avgq_milli,
  output logic [15:0]        dropped_count,
  output logic               overflow_sticky,
`ifdef NOC_TELEM_ARB_IRQ_EN
  input  logic [CNT_W-1:0]   arb_threshold,
`endif
  output logic               irq_arb
);

  localparam int WCW = $clog2(WINDOW_CYCLES);

  state_t           r_state;
  state_t           w_state_next;
  logic [WCW-1:0]   r_win;
  logic [CNT_W-1:0] r_prev_in;
  logic [CNT_W-1:0] r_prev_out;
  logic [CNT_W-1:0] r_prev_arb;
  logic [CNT_W-1:0] r_prev_buf;
  logic [SEQ_W-1:0] r_seq;
  logic [15:0]      r_dropped;
  logic             r_sticky;

  logic             w_win_last;
  logic             w_capture;
  logic             w_snapshot;
  logic [CNT_W-1:0] w_d_in;
  logic [CNT_W-1:0] w_d_out;
  logic [CNT_W-1:0] w_d_arb;
  logic [CNT_W-1:0] w_d_buf;
  telem_rec_t       w_rec;
  telem_rec_t       w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;

  assign w_win_last = (r_win == WCW'(WINDOW_CYCLES - 1));
  assign w_capture  = (r_state == CAPTURE);
  assign w_snapshot = (r_state == BASELINE) || w_capture;

  // Unsigned subtraction wraps modulo 2^32, so a counter rollover inside the
  // window still yields the true delta.
  assign w_d_in  = flits_in_count  - r_prev_in;
  assign w_d_out = flits_out_count - r_prev_out;
  assign w_d_arb = stall_arb_count - r_prev_arb;
  assign w_d_buf = stall_buf_count - r_prev_buf;

  always_comb begin
    w_rec            = '0;
    w_rec.seq        = SEQ_MAX_W'(r_seq);
    w_rec.d_in       = w_d_in;
    w_rec.d_out      = w_d_out;
    w_rec.d_arb      = w_d_arb;
    w_rec.d_buf      = w_d_buf;
    w_rec.peak_milli = peak_inflight_milli;
    w_rec.avgq_milli = avg_queue_depth_milli;
  end

  // Full FIFO loses the record unless the consumer pops the head this cycle.
  assign w_drop = w_capture && w_full && !(rec_ready && !w_empty);

  // ---- FSM next state ----
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (enable) w_state_next = BASELINE;
      BASELINE: w_state_next = RUN;
      // A window that has reached its end is captured even if enable drops.
      RUN: begin
        if (w_win_last)   w_state_next = CAPTURE;
        else if (!enable) w_state_next = IDLE;
      end
      CAPTURE:  w_state_next = enable ? RUN : IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  // ---- State, window counter, baselines, sequence, drop accounting ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_win      <= '0;
      r_prev_in  <= '0;
      r_prev_out <= '0;
      r_prev_arb <= '0;
      r_prev_buf <= '0;
      r_seq      <= '0;
      r_dropped  <= '0;
      r_sticky   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Counter only advances while the window keeps running; any exit clears it.
      if ((r_state == RUN) && enable && !w_win_last) r_win <= r_win + WCW'(1);
      else                                            r_win <= '0;
      if (w_snapshot) begin
        r_prev_in  <= flits_in_count;
        r_prev_out <= flits_out_count;
        r_prev_arb <= stall_arb_count;
        r_prev_buf <= stall_buf_count;
      end
      // Sequence advances even on a drop so the consumer sees the gap.
      if (w_capture) r_seq <= r_seq + SEQ_W'(1);
      if (w_drop) begin
        r_sticky <= 1'b1;
        if (r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
      end
    end
  end

  noc_telem_rec_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_capture),
    .i_data  (w_rec),
    .i_pop   (rec_ready),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign rec_valid       = !w_empty;
  assign rec_seq         = w_head.seq[SEQ_W-1:0];
  assign rec_d_in        = w_head.d_in;
  assign rec_d_out       = w_head.d_out;
  assign rec_d_arb       = w_head.d_arb;
  assign rec_d_buf       = w_head.d_buf;
  assign rec_peak_milli  = w_head.peak_milli;
  assign rec_avgq_milli  = w_head.avgq_milli;
  assign dropped_count   = r_dropped;
  assign overflow_sticky = r_sticky;

  // Upper record sequence bits are always zero for narrower SEQ_W.
  generate
    if (SEQ_W < SEQ_MAX_W) begin : g_seq_pad
      logic w_unused_seq_hi;
      assign w_unused_seq_hi = |w_head.seq[SEQ_MAX_W-1:SEQ_W];
    end
  endgenerate

`ifdef NOC_TELEM_ARB_IRQ_EN
  logic r_irq;

  // ---- Threshold pulse, one cycle after the window end ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_irq <= 1'b0;
    else          r_irq <= w_capture && (w_d_arb > arb_threshold);
  end

  assign irq_arb = r_irq;
`else
  assign irq_arb = 1'b0;
`endif

endmodule

// File: doc/noc_telem_window_sampler.md
Name: noc_telem_window_sampler

Overview:
- Sits directly downstream of noc_router_enhanced and consumes its cumulative telemetry counters.
- Divides time into fixed windows and, at each window end, computes per-window deltas of the router's free-running counters. It also latches the router's instantaneous milli metrics.
- Each result is queued as a record in a small FIFO, which a host or CSR bridge drains through a valid/ready handshake.

Parameters:
- WINDOW_CYCLES, 1024, cycles per sampling window (≥4).
- FIFO_DEPTH, 4, record slots (power of 2, ≥2).
- SEQ_W, 16, width of window sequence number.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  sampling enable (level).
- flits_in_count  in  32  router cumulative flits in.
- flits_out_count  in  32  router cumulative flits out.
- stall_arb_count  in  32  router cumulative arbitration stalls.
- stall_buf_count  in  32  router cumulative buffer stalls.
- peak_inflight_milli  in  16  router peak inflight metric.
- avg_queue_depth_milli  in  16  router average queue depth metric.
- rec_valid  out  1  FIFO head record valid.
- rec_ready  in  1  consumer accepts head record.
- rec_seq  out  SEQ_W  window sequence number of the head record.
- rec_d_in, rec_d_out, rec_d_arb, rec_d_buf  out  32 each  per-window deltas.
- rec_peak_milli, rec_avgq_milli  out  16 each  metrics latched at window end.
- dropped_count  out  16  records lost because the FIFO was full (saturating).
- overflow_sticky  out  1  set on the first drop; cleared only by reset.
- irq_arb  out  1  threshold pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Clock and reset: one clock domain. The reset_n assertion is asynchronous and active-low; deassertion is synchronised by the integrator.
- Reset values:
  - All outputs 0.
  - FIFO empty.
  - Sequence counter 0.
  - FSM in IDLE.
- FSM states:
  - IDLE: window counter holds at 0. On enable=1 → BASELINE.
  - BASELINE: one cycle. Snapshots the four 32-bit counters into prev registers. → RUN.
  - RUN: window counter increments each cycle.
    - When the counter reaches WINDOW_CYCLES-1 → CAPTURE.
    - When enable=0 → IDLE. The partial window is discarded and no record is made.
  - CAPTURE: one cycle.
    - Deltas are computed as cur - prev, modulo 2^32, so a counter wrap yields the correct delta.
    - The two milli inputs are latched.
    - The record is pushed. The prev registers are updated to cur, the sequence number increments (wrapping at 2^SEQ_W), and the window counter resets.
    - → RUN if enable=1, else IDLE.
- Window length: the first record closes WINDOW_CYCLES+1 cycles after enable is sampled high (BASELINE + WINDOW_CYCLES). Each subsequent window is WINDOW_CYCLES+1 cycles long, because CAPTURE counts as the boundary cycle.
- FIFO and output timing:
  - A record pushed in CAPTURE appears on rec_valid/rec_* the next cycle.
  - The outputs come from the registered FIFO head. They are stable while rec_valid=1 and rec_ready=0.
- Handshake: a pop occurs on rec_valid && rec_ready. The consumer may hold rec_ready high permanently.
- Full FIFO:
  - Push while full without a simultaneous pop → the record is dropped, dropped_count increments (saturating at 0xFFFF), and overflow_sticky is set. The prev registers and the sequence number still advance, so the seq gap is visible to the consumer.
  - Push and pop in the same cycle while full → both succeed; no drop.
- Empty FIFO: rec_valid=0 and rec_* hold their last values. rec_ready is ignored.
- enable deasserted: a pending CAPTURE still completes. Re-enabling always re-baselines, and sequence numbering continues where it left off.
- Reset mid-window: all state is cleared and no record is emitted.

Optional Feature:
- Macro: NOC_TELEM_ARB_IRQ_EN.
- With the macro defined:
  - Adds input arb_threshold [31:0].
  - In CAPTURE, if d_arb > arb_threshold, irq_arb pulses high for exactly one cycle, coinciding with the cycle after CAPTURE.
  - The pulse is independent of the FIFO drop.
- Without the macro: arb_threshold is absent and irq_arb is a constant 0.

Decomposition:
- Shared package noc_telem_pkg holds:
  - The telem_rec_t record struct (seq, four 32-bit deltas, two 16-bit milli fields).
  - The FSM state enum (IDLE, BASELINE, RUN, CAPTURE).
  - The constant CNT_W=32.
- One natural sub-module, noc_telem_rec_fifo: a synchronous FIFO of telem_rec_t with registered head and push/pop/full/empty. The FSM, delta arithmetic and drop accounting stay in the top module.

Test Plan:
- Window delta: WINDOW_CYCLES=16. Ramp flits_in_count +1/cycle from 100 and enable → first record has seq=0, rec_d_in=17 (BASELINE plus 16 RUN cycles), rec_valid appears at cycle 18 after enable.
- Wrap: stall_arb_count snapshot 0xFFFFFFF0 and 0x00000010 at CAPTURE → rec_d_arb=0x20.
- Overflow: FIFO_DEPTH=4, rec_ready=0, run 6 windows → 4 records held with seq 0..3, dropped_count=2, overflow_sticky=1. Draining then yields seq 0,1,2,3; the next record has seq 6.
- Full push+pop: FIFO full, rec_ready=1 exactly on the CAPTURE cycle → no drop, dropped_count unchanged.
- Enable gap: deassert enable mid-window at count 7, reassert 10 cycles later → no record for the partial window, the next record has the next seq and a delta measured from the new baseline.
- Reset mid-run: assert reset_n=0 during RUN with 2 records queued → rec_valid=0, dropped_count=0, seq restarts at 0. With NOC_TELEM_ARB_IRQ_EN and arb_threshold=5, a window with d_arb=6 produces a single irq_arb pulse.
